// File: rtl/core_mem_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the shared memory port.
// The arbiter uses the master view; the core and memory side use the slave view.
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              core_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              bus_err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, core_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, core_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with fixed data priority and a per-access watchdog that aborts hung accesses.
module core_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                reset,
    core_mem_arbiter_if.master bus
);

    localparam logic [15:0]       WDOG_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] NOP_INSN   = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              bus_err_q;
    logic [15:0]       wdog_q;
    logic [15:0]       wdog_d;
    logic              timeout;
    logic              d_elig;
    logic              if_elig;

    // A port whose valid is up this cycle is being released, not re-requesting.
    always_comb begin
        wdog_d  = wdog_q + 16'd1;
        timeout = (wdog_d == WDOG_LIMIT);
        d_elig  = bus.d_req & ~d_valid_q;
        if_elig = bus.if_req & ~if_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            wdog_q      <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_elig) begin
                        state_q     <= DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        wdog_q      <= '0;
                    end else if (if_elig) begin
                        state_q     <= FETCH;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        wdog_q      <= '0;
                    end
                end
                DATA, FETCH: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus.mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (state_q == FETCH) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (state_q == FETCH) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= NOP_INSN;
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= '0;
                            end
                        end
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.bus_err    = bus_err_q;
    // Held low in reset so every output reads zero while reset is asserted.
    assign bus.core_stall = ~reset & ((bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized bench for core_mem_arbiter: a latency-programmable memory responder
// plus a transaction-level reference model of grant order, latency and returned data.
module tb_core_mem_arbiter;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    core_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] ref_m [logic [31:0]];
    int          lat_q [$];
    logic        stray_ack = 1'b0;
    int          burst = 0;
    int          cur_lat = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_m.exists(a) ? ref_m[a] : dflt(a);
    endfunction

    // Memory: acks on the cur_lat-th cycle of each mem_req burst; 0 means never.
    always @(negedge clk) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        if (bus.mem_req === 1'b1) begin
            if (burst == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            burst++;
            if (burst == cur_lat) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = mem_m.exists(bus.mem_addr) ? mem_m[bus.mem_addr] : dflt(bus.mem_addr);
            end
        end else begin
            burst = 0;
            bus.mem_ack = stray_ack;
            bus.mem_rdata = 32'hBAD0_BAD0;
        end
    end

    logic [31:0] exp_drd = 32'h0;
    logic        exp_err = 1'b0;

    task automatic run_case(input string nm, input bit use_f, input bit use_d, input bit we,
                            input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                            input int lf, input int ld);
        bit to_f, to_d, exp_mreq;
        int lf_e, ld_e, vf, vd, fs, last, f_at, d_at, f_n, d_n, stall_n, bad_bus;
        logic [31:0] got_if, got_d, exp_if, exp_d;
        to_f = use_f && (lf == 0 || lf > T);
        to_d = use_d && (ld == 0 || ld > T);
        lf_e = to_f ? T : lf;
        ld_e = to_d ? T : ld;
        vd   = use_d ? ld_e : -1;
        fs   = use_d ? ld_e + 1 : 0;
        vf   = use_f ? fs + lf_e : -1;
        last = (vf > vd) ? vf : vd;
        exp_if = to_f ? 32'h0000_0013 : ref_rd(fa);
        exp_d  = we ? exp_drd : (to_d ? 32'h0 : ref_rd(da));
        if (use_d) lat_q.push_back(ld);
        if (use_f) lat_q.push_back(lf);
        f_at = -1; d_at = -1; f_n = 0; d_n = 0; bad_bus = 0;
        got_if = 32'h0; got_d = 32'h0;
        bus.if_req = use_f; bus.if_addr = fa;
        bus.d_req = use_d; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
        #1;
        stall_n = (bus.core_stall === 1'b1) ? 1 : 0;
        for (int j = 0; j <= last + 3; j++) begin
            @(posedge clk);
            #1;
            exp_mreq = (use_d && j < vd) || (use_f && j >= fs && j < vf);
            if (bus.mem_req !== exp_mreq) bad_bus++;
            else if (exp_mreq) begin
                if (use_d && j < vd) begin
                    if (bus.mem_addr !== da || bus.mem_we !== we || (we && bus.mem_wdata !== wd)) bad_bus++;
                end else if (bus.mem_addr !== fa || bus.mem_we !== 1'b0) bad_bus++;
            end
            if (bus.core_stall === 1'b1) stall_n++;
            if (bus.if_valid === 1'b1) begin
                f_n++;
                if (f_at < 0) begin f_at = j; got_if = bus.if_rdata; end
            end
            if (bus.d_valid === 1'b1) begin
                d_n++;
                if (d_at < 0) begin d_at = j; got_d = bus.d_rdata; end
            end
            @(negedge clk);
            if (f_at == j) bus.if_req = 1'b0;
            if (d_at == j) bus.d_req = 1'b0;
        end
        if (use_d && we && !to_d) ref_m[da] = wd;
        if (use_d) exp_drd = exp_d;
        exp_err = exp_err | to_f | to_d;
        if (use_f) begin
            chk({nm, ".if_valid_at"}, 32'(f_at), 32'(vf));
            chk({nm, ".if_pulses"}, 32'(f_n), 32'd1);
            chk({nm, ".if_rdata"}, got_if, exp_if);
        end
        if (use_d) begin
            chk({nm, ".d_valid_at"}, 32'(d_at), 32'(vd));
            chk({nm, ".d_pulses"}, 32'(d_n), 32'd1);
            chk({nm, ".d_rdata"}, got_d, exp_d);
        end
        chk({nm, ".stall_cycles"}, 32'(stall_n), 32'(last + 1));
        chk({nm, ".bus_seq_errs"}, 32'(bad_bus), 32'd0);
        chk({nm, ".bus_err"}, 32'(bus.bus_err), 32'(exp_err));
        chk({nm, ".d_rdata_hold"}, bus.d_rdata, exp_drd);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({nm, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({nm, ".mem_addr"}, bus.mem_addr, 32'd0);
        chk({nm, ".mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({nm, ".if_rdata"}, bus.if_rdata, 32'd0);
        chk({nm, ".d_rdata"}, bus.d_rdata, 32'd0);
        chk({nm, ".valids"}, {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
        chk({nm, ".bus_err"}, 32'(bus.bus_err), 32'd0);
        chk({nm, ".core_stall"}, 32'(bus.core_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        mem_m[32'h40] = 32'h0050_0093;  ref_m[32'h40] = 32'h0050_0093;
        mem_m[32'h200] = 32'h1234_5678; ref_m[32'h200] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        run_case("fetch1", 1, 0, 0, 32'h40, 32'h0, 32'h0, 1, 0);
        run_case("both_st", 1, 1, 1, 32'h44, 32'h100, 32'hDEAD_BEEF, 3, 3);
        run_case("load_ack_last", 0, 1, 0, 32'h0, 32'h200, 32'h0, 0, T);
        run_case("load_st_back", 0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 2);
        run_case("to_fetch", 1, 0, 0, 32'h48, 32'h0, 32'h0, 0, 0);
        run_case("to_load", 0, 1, 0, 32'h0, 32'h204, 32'h0, 0, 0);
        run_case("err_sticky", 1, 0, 0, 32'h4C, 32'h0, 32'h0, 2, 0);

        @(posedge clk); #2 stray_ack = 1'b1;
        @(posedge clk); #2 stray_ack = 1'b0;
        @(posedge clk); #1;
        chk("stray_ack.valids", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
        chk("stray_ack.mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            bit uf, ud, w;
            uf = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!uf && !ud) uf = 1'b1;
            w = 1'($urandom_range(0, 1));
            run_case($sformatf("rnd%0d", i), uf, ud, w,
                     32'($urandom_range(0, 1023)) << 2,
                     32'h1000_0000 + (32'($urandom_range(0, 15)) << 2),
                     $urandom,
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_0010;
        lat_q.push_back(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rst.pre_mem_req", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst.no_d_valid", 32'(bus.d_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_err = 1'b0;
        exp_drd = 32'h0;
        @(negedge clk);
        run_case("post_rst", 1, 1, 0, 32'h80, 32'h200, 32'h0, 2, 1);
        chk("lat_queue_drained", 32'(lat_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
